cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_FU, default 4: number of functional-unit completion ports.
REQ-002 Parameter FIFO_DEPTH, default 2: completion-queue depth per port.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 fu_valid  in  N_FU  per-port completion strobe.
REQ-006 fu_tag  in  N_FU x $clog2(ROB_LEN)  ROB index of completing instruction.
REQ-007 fu_value  in  N_FU x XLEN  result value.
REQ-008 fu_wb_en  in  N_FU  result writes a destination register.
REQ-009 fu_correct_predict  in  N_FU  0 = branch mispredicted; non-branch units drive 1.
REQ-010 squash  in  1  ROB head mispredict flush.
REQ-011 fu_ready  out  N_FU  port queue can accept a completion this cycle.
REQ-012 cdb_packet_out  out  CDB_PACKET  registered broadcast: no_output, reg_tag.tag, reg_tag.valid, reg_value, correct_predict.

Function
REQ-013 Each port SHALL own a FIFO of FIFO_DEPTH entries {tag, value, wb_en, correct_predict}.
REQ-014 fu_ready[i] SHALL be 1 iff port i occupancy < FIFO_DEPTH, with no credit for a same-cycle pop.
REQ-015 fu_valid[i]=1 with fu_ready[i]=1 SHALL push at the clock edge; with fu_ready[i]=0 the completion is dropped and counts as a protocol error.
REQ-016 A port SHALL be eligible when its FIFO is non-empty.
REQ-017 Exactly one eligible port SHALL be granted per cycle, round-robin: lowest index >= rr_ptr, wrapping to 0.
REQ-018 On a grant to port g, rr_ptr SHALL become (g+1) mod N_FU; with no grant, rr_ptr SHALL hold.
REQ-019 The granted entry SHALL be popped and registered into cdb_packet_out with no_output=0 and reg_tag.valid=wb_en.
REQ-020 With no grant, cdb_packet_out SHALL show no_output=1 and all other fields 0.
REQ-021 Base latency SHALL be 2 cycles: push at edge t, broadcast visible after edge t+1 when uncontended.
REQ-022 Push and pop on the same port in one cycle SHALL leave occupancy unchanged and preserve FIFO order.
REQ-023 On squash=1, all FIFOs SHALL empty at the next edge, that cycle's pushes and grant SHALL be discarded, cdb_packet_out SHALL become no_output=1, and rr_ptr SHALL hold.
REQ-024 Per-port completions SHALL broadcast in arrival order; cross-port order is governed only by REQ-017.

Reset
REQ-025 While reset=0: FIFOs empty, rr_ptr=0, cdb_packet_out no_output=1 with other fields 0, fu_ready all 0.
REQ-026 On the first cycle after reset deasserts, fu_ready SHALL be all 1.
REQ-027 A reset assertion mid-broadcast SHALL discard all queued completions immediately and asynchronously.

Configuration
REQ-028 Macro CDB_BYPASS_EN.
REQ-029 Defined: a port with an empty FIFO and fu_valid=1 SHALL also be eligible that cycle. If granted, the entry is broadcast after edge t (latency 1) and not pushed. Otherwise it is pushed.
REQ-030 Undefined: no bypass; latency per REQ-021.
REQ-031 Squash SHALL override bypass in both builds.

Structure
REQ-032 CDB_PACKET, the FU completion entry typedef, ROB_LEN and XLEN SHALL come from the shared sys_defs package.
REQ-033 The per-port queue SHALL be sub-module cdb_fu_fifo (push, pop, full, empty, head), instantiated N_FU times.

Verification
REQ-034 Reset release, no fu_valid for 5 cycles -> no_output=1 every cycle; fu_ready=4'b1111.
REQ-035 Port 2 pushes tag=5, value=32'hDEAD_BEEF, wb_en=1, cp=1 at cycle 0 -> cycle 2 shows tag 5, value DEADBEEF, reg_tag.valid=1, no_output=0. With CDB_BYPASS_EN this appears at cycle 1.
REQ-036 All 4 ports push in the same cycle with tags 1..4 and rr_ptr=0 -> broadcasts tags 1,2,3,4 on 4 consecutive cycles; rr_ptr returns to 0.
REQ-037 Port 0 pushes 3 times back-to-back with no pops possible (ports 1-3 busy) -> fu_ready[0] deasserts after 2 pushes; the third push is flagged as a protocol error.
REQ-038 3 entries queued, squash=1 for one cycle -> next cycle no_output=1, all FIFOs empty, fu_ready all 1, nothing broadcast afterward.
REQ-039 Port 1 pushes tag=7, cp=0 -> broadcast has correct_predict=0 and tag 7.

Source files
------------

// File: rtl/sys_defs.sv
// sys_defs: shared machine-wide widths and the completion/broadcast packet types.
// Revision: 1.0
`default_nettype none

package sys_defs;

   localparam int XLEN      = 32;
   localparam int ROB_LEN   = 32;
   localparam int ROB_IDX_W = $clog2(ROB_LEN);

   typedef struct packed {
      logic [ROB_IDX_W-1:0] tag;
      logic                 valid;
   } REG_TAG;

   typedef struct packed {
      logic            no_output;
      REG_TAG          reg_tag;
      logic [XLEN-1:0] reg_value;
      logic            correct_predict;
   } CDB_PACKET;

   typedef struct packed {
      logic [ROB_IDX_W-1:0] tag;
      logic [XLEN-1:0]      value;
      logic                 wb_en;
      logic                 correct_predict;
   } FU_ENTRY;

   function automatic CDB_PACKET cdb_idle();
      CDB_PACKET p;
      p           = '0;
      p.no_output = 1'b1;
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_fu_fifo.sv
// cdb_fu_fifo: per-port completion queue, circular buffer with synchronous flush.
// Revision: 1.0
`default_nettype none

module cdb_fu_fifo
   import sys_defs::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    flush_i,
   input  logic    push_i,
   input  logic    pop_i,
   input  FU_ENTRY din_i,
   output logic    full_o,
   output logic    empty_o,
   output FU_ENTRY head_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   FU_ENTRY              mem_q [DEPTH];
   logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 w_push, w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   assign w_push = push_i & ~full_o & ~flush_i;
   assign w_pop  = pop_i & ~empty_o & ~flush_i;

   // Storage carries no reset: validity is tracked entirely by cnt_q.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({w_push, w_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of N_FU completion queues onto one registered CDB.
// Optional macro CDB_BYPASS_EN lets an empty port's incoming completion win the bus directly.
// Revision: 1.0
`default_nettype none

module cdb_arbiter
   import sys_defs::*;
#(
   parameter int N_FU       = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_FU-1:0]                 fu_valid_i,
   input  logic [N_FU-1:0][ROB_IDX_W-1:0]  fu_tag_i,
   input  logic [N_FU-1:0][XLEN-1:0]       fu_value_i,
   input  logic [N_FU-1:0]                 fu_wb_en_i,
   input  logic [N_FU-1:0]                 fu_correct_predict_i,
   input  logic                            squash_i,
   output logic [N_FU-1:0]                 fu_ready_o,
   output logic [N_FU-1:0]                 proto_err_o,
   output CDB_PACKET                       cdb_packet_o
);

   localparam int RR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

   FU_ENTRY           w_in   [N_FU];
   FU_ENTRY           w_head [N_FU];
   logic [N_FU-1:0]   w_full, w_empty, w_push, w_pop, w_elig;
   logic              w_grant_vld, w_byp;
   logic [RR_W-1:0]   w_grant_idx;
   FU_ENTRY           w_sel;
   logic [RR_W-1:0]   rr_q, rr_d;
   CDB_PACKET         pkt_q, pkt_d;

   // Ready is forced low while reset is held so no completion is accepted then.
   assign fu_ready_o   = ~w_full & {N_FU{rst_n}};
   assign proto_err_o  = fu_valid_i & ~fu_ready_o;
   assign cdb_packet_o = pkt_q;

`ifdef CDB_BYPASS_EN
   assign w_elig = ~w_empty | fu_valid_i;
`else
   assign w_elig = ~w_empty;
`endif

   generate
      for (genvar gi = 0; gi < N_FU; gi++) begin : g_port
         assign w_in[gi] = '{tag:             fu_tag_i[gi],
                             value:           fu_value_i[gi],
                             wb_en:           fu_wb_en_i[gi],
                             correct_predict: fu_correct_predict_i[gi]};

         assign w_pop[gi]  = w_grant_vld & ~w_byp & (w_grant_idx == RR_W'(gi)) & ~squash_i;
         assign w_push[gi] = fu_valid_i[gi] & fu_ready_o[gi] & ~squash_i
                             & ~(w_byp & (w_grant_idx == RR_W'(gi)));

         cdb_fu_fifo #(
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (squash_i),
            .push_i  (w_push[gi]),
            .pop_i   (w_pop[gi]),
            .din_i   (w_in[gi]),
            .full_o  (w_full[gi]),
            .empty_o (w_empty[gi]),
            .head_o  (w_head[gi])
         );
      end
   endgenerate

   // Scan ports starting at rr_q, wrapping, and take the first eligible one.
   always_comb begin
      int              idx;
      logic [RR_W-1:0] idx_w;
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      for (int k = 0; k < N_FU; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= N_FU) idx = idx - N_FU;
         idx_w = RR_W'(idx);
         if (!w_grant_vld && w_elig[idx_w]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = idx_w;
         end
      end
   end

   assign w_byp = w_grant_vld & w_empty[w_grant_idx];
   assign w_sel = w_byp ? w_in[w_grant_idx] : w_head[w_grant_idx];

   always_comb begin
      pkt_d = cdb_idle();
      rr_d  = rr_q;
      if (w_grant_vld && !squash_i) begin
         pkt_d.no_output       = 1'b0;
         pkt_d.reg_tag.tag     = w_sel.tag;
         pkt_d.reg_tag.valid   = w_sel.wb_en;
         pkt_d.reg_value       = w_sel.value;
         pkt_d.correct_predict = w_sel.correct_predict;
         rr_d = (w_grant_idx == RR_W'(N_FU - 1)) ? '0 : w_grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_q <= cdb_idle();
         rr_q  <= '0;
      end else begin
         pkt_q <= pkt_d;
         rr_q  <= rr_d;
      end
   end

endmodule

`default_nettype wire
